// File: rtl/lock_pkg.sv
// Shared types and helpers for the digital-lock core.
// State encoding, BCD constants and the digit-increment helper.
package lock_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    FAIL,
    LOCKOUT
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero.
// Ports: clk_in, rst, load, load_val, en -> count, zero.
module lock_timer #(
  parameter int W = 28
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk_in) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_code_entry.sv
// Digital-lock core: BCD code entry, check, unlock and lockout.
// Ports: clk_in, rst, inc/next/hold pulses -> status outputs.
module lock_code_entry
  import lock_pkg::*;
#(
  parameter int                         NUM_DIGITS     = 4,
  parameter logic [4*NUM_DIGITS-1:0]    CODE           = 16'h1234,
  parameter int                         MAX_FAIL       = 3,
  parameter logic [27:0]                UNLOCK_CYCLES  = 28'd100_000_000,
  parameter logic [27:0]                LOCKOUT_CYCLES = 28'd200_000_000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       inc_pulse,
  input  logic       next_pulse,
  input  logic       hold_pulse,
  output logic       unlocked,
  output logic       locked_out,
  output logic       err_pulse,
  output logic [2:0] digit_idx,
  output logic [3:0] cur_digit,
  output logic [3:0] fail_cnt
);

  localparam int          BW         = DIGIT_W * NUM_DIGITS;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [27:0] UNLOCK_LD  = UNLOCK_CYCLES - 28'd1;
  localparam logic [27:0] LOCKOUT_LD = LOCKOUT_CYCLES - 28'd1;
  localparam logic [3:0]  FAIL_LIM   = 4'(MAX_FAIL);

  state_t        state, state_n;
  logic [BW-1:0] code_buf, code_buf_n;
  logic [2:0]    idx_n;
  logic [3:0]    cur_n;
  logic [3:0]    fail_n;
  logic          t_load;
  logic [27:0]   t_val;
  logic          t_en;
  logic          t_zero;
  logic [27:0]   t_count;

  lock_timer #(.W(28)) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .count    (t_count),
    .zero     (t_zero)
  );

  always_comb begin
    state_n    = state;
    code_buf_n = code_buf;
    idx_n      = digit_idx;
    cur_n      = cur_digit;
    fail_n     = fail_cnt;
    t_load     = 1'b0;
    t_val      = UNLOCK_LD;
    t_en       = 1'b0;
    unique case (state)
      ENTRY: begin
        if (hold_pulse) begin
          code_buf_n = '0;
          idx_n      = '0;
          cur_n      = '0;
        end else if (next_pulse) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (digit_idx == 3'(i))
              code_buf_n[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = cur_digit;
          if (digit_idx == LAST_IDX) begin
            state_n = CHECK;
          end else begin
            idx_n = digit_idx + 3'd1;
            cur_n = '0;
          end
        end else if (inc_pulse) begin
          cur_n = bcd_inc(cur_digit);
        end
      end
      CHECK: begin
        if (code_buf == CODE) begin
          state_n = OPEN;
          fail_n  = '0;
          t_load  = 1'b1;
          t_val   = UNLOCK_LD;
        end else begin
          fail_n = (fail_cnt == 4'hf) ? 4'hf : fail_cnt + 4'd1;
          if (fail_n == FAIL_LIM) begin
            state_n = LOCKOUT;
            t_load  = 1'b1;
            t_val   = LOCKOUT_LD;
          end else begin
            state_n = FAIL;
          end
        end
      end
      OPEN: begin
        t_en = 1'b1;
        if (t_zero || hold_pulse) begin
          state_n    = ENTRY;
          code_buf_n = '0;
          idx_n      = '0;
          cur_n      = '0;
        end
      end
      FAIL: begin
        state_n    = ENTRY;
        code_buf_n = '0;
        idx_n      = '0;
        cur_n      = '0;
      end
      LOCKOUT: begin
        t_en = 1'b1;
        if (t_zero) begin
          state_n    = ENTRY;
          fail_n     = '0;
          code_buf_n = '0;
          idx_n      = '0;
          cur_n      = '0;
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the cycle the FSM actually spends in that state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= ENTRY;
      code_buf   <= '0;
      digit_idx  <= '0;
      cur_digit  <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      code_buf   <= code_buf_n;
      digit_idx  <= idx_n;
      cur_digit  <= cur_n;
      fail_cnt   <= fail_n;
      unlocked   <= (state_n == OPEN);
      locked_out <= (state_n == LOCKOUT);
      err_pulse  <= (state_n == FAIL) ||
                    (state == CHECK && state_n == LOCKOUT);
    end
  end

endmodule
